// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage buffer: DEPTH-entry circular FIFO with valid/ready handshake,
// zero bubble on empty, synchronous flush and a saturating bubble counter.
module pipe_stage_buf #(
  parameter int unsigned WIDTH = 80,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count,
  output logic [15:0]      bubble_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0]  LastPtr  = PtrW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      bubble_q, bubble_d;
  logic             push, pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on registered occupancy, so a pop never frees a slot the same cycle.
  assign in_ready   = (count_q < DepthCnt);
  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;
  assign bubble_cnt = bubble_q;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    bubble_d = bubble_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    if (out_ready && !out_valid && !flush && (bubble_q != 16'hFFFF)) begin
      bubble_d = bubble_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      bubble_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      bubble_q <= bubble_d;
      if (push) mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed per-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one opaque payload bus, sized by WIDTH, through a DEPTH-entry elastic buffer with a valid/ready handshake. This replaces the global stall-vector scheme with local backpressure.
- Presents an all-zero payload (bubble) whenever empty. Provides a synchronous flush for branch/exception squash and a bubble statistics counter.
- Instantiated between any two pipeline stages.

Parameters:
- WIDTH, 80: payload width in bits (packed control + data fields of a stage).
- DEPTH, 2: buffer entries; legal 1..8. DEPTH=1 gives half throughput; DEPTH>=2 gives full throughput.
- CNT_W, $clog2(DEPTH+1): width of occupancy count. Derived; do not override.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all buffered entries.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  buffer can accept a payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream consumes the head this cycle.
- out_data  out  WIDTH  head payload; all zeros when out_valid=0.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- bubble_cnt  out  16  saturating count of cycles where downstream was ready but received a bubble.

Behaviour:
- Storage: circular buffer of DEPTH entries with rd_ptr and wr_ptr. Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
- push = in_valid && in_ready && !flush
- pop = out_valid && out_ready && !flush
- in_ready = (count < DEPTH). Derived from registered state only; there is no combinational path from out_ready to in_ready. Consequently, when full, a simultaneous pop does not enable a push that cycle.
- out_valid = (count != 0).
- out_data = mem[rd_ptr] when out_valid, else 0. The zero bubble means every control bit is deasserted (no reg write, no load/store).
- Latency: a payload pushed at edge N is visible on out_data after edge N (one cycle), provided all earlier entries are gone.
- Ordering is strictly FIFO; payloads are never duplicated or dropped except by flush.
- Count update per edge:
  - push and pop together: count unchanged, both pointers advance.
  - push only: count+1.
  - pop only: count-1.
- flush=1 at an edge:
  - count, rd_ptr and wr_ptr go to 0.
  - in_data is not captured, even if in_valid=1.
  - The next cycle has out_valid=0 and out_data=0.
  - bubble_cnt is unaffected by flush.
- bubble_cnt: increments at an edge when out_ready=1 && out_valid=0 && !flush, and saturates at 16'hFFFF. Cleared only by reset.
- Reset (reset=0, asynchronous, any time including mid-transfer):
  - count=0, pointers=0, bubble_cnt=0, all storage entries zeroed.
  - Outputs immediately: out_valid=0, out_data=0, in_ready=1.
  - On deassertion, the first push can occur at the first clock edge.
- A push with in_valid=1 while in_ready=0 is ignored. Upstream must hold in_data stable until accepted.
- Storage words are written only on push. No other storage writes occur except reset.

Test Plan:
- Reset then idle: reset low 3 cycles with in_valid=1, in_data=0xAB -> count=0, out_valid=0, out_data=0, in_ready=1. After release with out_ready=1, bubble_cnt counts 1,2,3... until the first push.
- Streaming, DEPTH=2, out_ready=1: push 0x1,0x2,0x3 on consecutive edges -> out_data 0x1,0x2,0x3 on the following consecutive cycles, count stays 1, in_ready stays 1.
- Backpressure, DEPTH=2: out_ready=0, push 0x10,0x11,0x12 -> count=2, in_ready=0, 0x12 held upstream. Then out_ready=1 -> 0x10 popped, next cycle in_ready=1, 0x12 accepted, order 0x10,0x11,0x12.
- Full with simultaneous pop: count=2, out_ready=1, in_valid=1 -> exactly one pop, no push, count=1.
- Flush: count=2 holding 0x20,0x21, flush=1 together with in_valid=1/in_data=0x22 -> next cycle count=0, out_data=0. 0x22 is lost and 0x20/0x21 never appear. bubble_cnt is unchanged across the flush edge.
- Saturation and async reset: force 70000 bubble cycles -> bubble_cnt=0xFFFF and holds. Assert reset between clock edges -> bubble_cnt=0 and count=0 before the next edge.
